// File: rtl/branch_predict_unit_pkg.sv
// Shared branch encodings and BHT counter state codes for the branch predict unit.
package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-side signals of the branch predict unit: IF prediction lookup and EX resolution.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_B;
  logic [2:0]      ex_funct3;
  logic            ex_Z;
  logic            ex_C;
  logic            ex_V;
  logic            ex_S;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            stall;
  logic            branch_taken;
  logic            mispredict;

  modport master (
    output if_pc, ex_valid, ex_B, ex_funct3, ex_Z, ex_C, ex_V, ex_S, ex_pc,
           ex_pred_taken, stall,
    input  if_pred_taken, branch_taken, mispredict
  );

  modport slave (
    input  if_pc, ex_valid, ex_B, ex_funct3, ex_Z, ex_C, ex_V, ex_S, ex_pc,
           ex_pred_taken, stall,
    output if_pred_taken, branch_taken, mispredict
  );
endinterface

// File: rtl/branch_predict_unit_cond_eval.sv
// Combinational branch condition evaluator: funct3 against ALU flags, plus funct3 legality.
module branch_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  input  logic       s,
  output logic       taken,
  output logic       legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      BR_BEQ:  taken = z;
      BR_BNE:  taken = ~z;
      BR_BLT:  taken = s ^ v;
      BR_BGE:  taken = ~(s ^ v);
      BR_BLTU: taken = ~c;
      BR_BGEU: taken = c;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: 2-bit BHT lookup in IF, EX-stage resolution/training, saturating perf counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int BHT_ENTRIES = 64,
  parameter  int PERF_W      = 32,
  localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predict_unit_if.slave bpu,
  output logic [PERF_W-1:0] br_count,
  output logic [PERF_W-1:0] mp_count
);

  function automatic logic [1:0] bht_next(input logic [1:0] st, input logic taken);
    if (taken) return (st == BHT_ST)  ? BHT_ST  : st + 2'd1;
    else       return (st == BHT_SNT) ? BHT_SNT : st - 2'd1;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond_taken;
  logic             cond_legal;
  logic             resolving;
  logic             upd;
  logic [XLEN-1:0]  unused_pc;

  // Word-aligned PCs: bits [1:0] are skipped, upper bits alias onto the same counter.
  assign if_idx    = bpu.if_pc[IDX_W+1:2];
  assign ex_idx    = bpu.ex_pc[IDX_W+1:2];
  assign unused_pc = bpu.if_pc ^ bpu.ex_pc;

  branch_cond_eval u_cond (
    .funct3 (bpu.ex_funct3),
    .z      (bpu.ex_Z),
    .c      (bpu.ex_C),
    .v      (bpu.ex_V),
    .s      (bpu.ex_S),
    .taken  (cond_taken),
    .legal  (cond_legal)
  );

  assign resolving         = bpu.ex_valid & bpu.ex_B;
  assign bpu.branch_taken  = resolving & cond_legal & cond_taken;
  assign bpu.mispredict    = resolving & (bpu.branch_taken ^ bpu.ex_pred_taken);
  assign upd               = resolving & cond_legal & ~bpu.stall;
  // No write bypass: a same-cycle update shows up on the next cycle's lookup.
  assign bpu.if_pred_taken = bht[if_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= BHT_WNT;
      br_count <= '0;
      mp_count <= '0;
    end else if (upd) begin
      bht[ex_idx] <= bht_next(bht[ex_idx], bpu.branch_taken);
      br_count    <= sat_inc(br_count);
      if (bpu.mispredict) mp_count <= sat_inc(mp_count);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: reset, condition sweep, training, stall, illegal, saturation.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int XLEN   = 32;
  localparam int PERF_W = 4;

  logic              clk;
  logic              rst_n;
  logic [PERF_W-1:0] br_count;
  logic [PERF_W-1:0] mp_count;
  int                checks;
  int                errors;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (64),
    .PERF_W      (PERF_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bpu      (bus),
    .br_count (br_count),
    .mp_count (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_taken(input logic [2:0] f3, input logic z, c, v, s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s != v;
      3'b101:  return s == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_br(input logic [2:0] f3, input logic z, input logic [31:0] pc,
                          input logic pred, input logic stl);
    bus.ex_valid      = 1'b1;
    bus.ex_B          = 1'b1;
    bus.ex_funct3     = f3;
    bus.ex_Z          = z;
    bus.ex_C          = 1'b0;
    bus.ex_V          = 1'b0;
    bus.ex_S          = 1'b0;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pred;
    bus.stall         = stl;
    #1;
  endtask

  initial begin
    logic [2:0] codes [6];
    logic [3:0] fl;
    logic       et;
    checks = 0;
    errors = 0;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b100;
    codes[3] = 3'b101; codes[4] = 3'b110; codes[5] = 3'b111;

    rst_n             = 1'b0;
    bus.if_pc         = 32'h40;
    bus.ex_valid      = 1'b0;
    bus.ex_B          = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_Z          = 1'b0;
    bus.ex_C          = 1'b0;
    bus.ex_V          = 1'b0;
    bus.ex_S          = 1'b0;
    bus.ex_pc         = 32'h0;
    bus.ex_pred_taken = 1'b0;
    bus.stall         = 1'b0;
    #2;
    chk("reset_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("reset_br", {28'd0, br_count}, 32'd0);
    chk("reset_mp", {28'd0, mp_count}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Condition sweep under stall so counters and BHT stay untouched
    bus.ex_valid      = 1'b1;
    bus.ex_B          = 1'b1;
    bus.ex_pred_taken = 1'b0;
    bus.stall         = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int f = 0; f < 16; f++) begin
        fl = f[3:0];
        bus.ex_funct3 = codes[i];
        {bus.ex_Z, bus.ex_C, bus.ex_V, bus.ex_S} = fl;
        #1;
        et = exp_taken(codes[i], fl[3], fl[2], fl[1], fl[0]);
        chk($sformatf("taken_f%0d_zcvs%0h", codes[i], fl), {31'd0, bus.branch_taken}, {31'd0, et});
        chk($sformatf("mp_f%0d_zcvs%0h", codes[i], fl), {31'd0, bus.mispredict}, {31'd0, et});
      end
    end
    tick();
    chk("sweep_stall_br", {28'd0, br_count}, 32'd0);
    chk("sweep_stall_mp", {28'd0, mp_count}, 32'd0);

    bus.ex_valid = 1'b0;
    bus.ex_funct3 = BR_BEQ; bus.ex_Z = 1'b1; bus.ex_pred_taken = 1'b1;
    #1;
    chk("novalid_taken", {31'd0, bus.branch_taken}, 32'd0);
    chk("novalid_mp", {31'd0, bus.mispredict}, 32'd0);

    // Training at 0x40 with collision on the first resolve
    bus.if_pc = 32'h40;
    drive_br(BR_BEQ, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("train1_old_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("train1_mp", {31'd0, bus.mispredict}, 32'd1);
    tick();
    chk("train1_new_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    drive_br(BR_BEQ, 1'b1, 32'h40, 1'b1, 1'b0);
    chk("train2_mp", {31'd0, bus.mispredict}, 32'd0);
    tick();
    chk("train2_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    drive_br(BR_BEQ, 1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    drive_br(BR_BEQ, 1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    chk("train_br", {28'd0, br_count}, 32'd4);
    chk("train_mp", {28'd0, mp_count}, 32'd1);
    bus.if_pc = 32'h140;
    #1;
    chk("alias_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    bus.if_pc = 32'h44;
    #1;
    chk("other_idx_pred", {31'd0, bus.if_pred_taken}, 32'd0);

    // Decrement from ST: 11 -> 10 -> 01
    bus.if_pc = 32'h40;
    drive_br(BR_BNE, 1'b1, 32'h40, 1'b1, 1'b0);
    chk("dec_taken", {31'd0, bus.branch_taken}, 32'd0);
    tick();
    chk("dec1_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    drive_br(BR_BNE, 1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    chk("dec2_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("dec_br", {28'd0, br_count}, 32'd6);
    chk("dec_mp", {28'd0, mp_count}, 32'd3);

    // Taken branch under stall changes nothing
    bus.if_pc = 32'h44;
    drive_br(BR_BEQ, 1'b1, 32'h44, 1'b0, 1'b1);
    chk("stall_taken", {31'd0, bus.branch_taken}, 32'd1);
    tick();
    chk("stall_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("stall_br", {28'd0, br_count}, 32'd6);
    chk("stall_mp", {28'd0, mp_count}, 32'd3);

    // Illegal funct3 on an entry sitting at WT
    bus.if_pc = 32'h48;
    drive_br(BR_BEQ, 1'b1, 32'h48, 1'b0, 1'b0);
    tick();
    chk("wt_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    drive_br(3'b010, 1'b1, 32'h48, 1'b1, 1'b0);
    chk("illegal_taken", {31'd0, bus.branch_taken}, 32'd0);
    chk("illegal_mp", {31'd0, bus.mispredict}, 32'd1);
    tick();
    chk("illegal_pred", {31'd0, bus.if_pred_taken}, 32'd1);
    chk("illegal_br", {28'd0, br_count}, 32'd7);
    chk("illegal_mp_cnt", {28'd0, mp_count}, 32'd4);

    // Reset mid-cycle with an update pending
    drive_br(BR_BEQ, 1'b1, 32'h48, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    chk("midrst_br", {28'd0, br_count}, 32'd0);
    chk("midrst_mp", {28'd0, mp_count}, 32'd0);
    tick();
    chk("midrst_hold_pred", {31'd0, bus.if_pred_taken}, 32'd0);
    bus.ex_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Saturation of 4-bit perf counters
    drive_br(BR_BEQ, 1'b0, 32'h4C, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) tick();
    chk("sat10_br", {28'd0, br_count}, 32'd10);
    chk("sat10_mp", {28'd0, mp_count}, 32'd10);
    for (int n = 0; n < 10; n++) tick();
    chk("sat20_br", {28'd0, br_count}, 32'd15);
    chk("sat20_mp", {28'd0, mp_count}, 32'd15);
    tick();
    chk("sat_hold_br", {28'd0, br_count}, 32'd15);
    chk("sat_hold_mp", {28'd0, mp_count}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
